demux_stream_1xn: RTL and testbench

- Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Each output channel has a one-entry holding register.
- Optional packet mode latches the destination on the first beat of a packet and holds it until the beat carrying in_last.
- Sits between a single producer and N consumer channels; successor of the combinational 1x2/1x4/1x8 demux blocks.

---
 rtl/demux_stream_1xn_if.sv | 26 ++
 rtl/demux_stream_1xn.sv | 136 +++++++++++++
 tb/tb_demux_stream_1xn.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_1xn_if.sv
// Stream bundle for the 1-to-N demultiplexer: one producer-side input stream
// plus N consumer channels packed side by side.
interface demux_stream_1xn_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_last;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic [N_OUT*DATA_W-1:0] out_data;

    // master: the environment (producer + consumers); slave: the demux itself
    modport master (
        output in_valid, in_data, in_sel, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_sel, in_last, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N stream demux with a one-entry holding register per channel,
// optional packet lock, and a saturating counter of discarded beats.
module demux_stream_1xn #(
    parameter int DATA_W   = 8,
    parameter int N_OUT    = 8,
    parameter int SEL_W    = 3,
    parameter int PKT_MODE = 1,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_stream_1xn_if.slave    bus,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 busy
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    // One extra bit so N_OUT == 2**SEL_W is still representable
    localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

    state_t                r_state;
    state_t                w_state_next;
    logic [SEL_W-1:0]      r_locked_sel;
    logic [SEL_W-1:0]      w_locked_sel_next;
    logic [N_OUT-1:0]      r_valid;
    logic [DATA_W-1:0]     r_data [N_OUT];
    logic [CNT_W-1:0]      r_drop_cnt;

    logic [SEL_W-1:0]      w_tgt;
    logic                  w_tgt_ok;
    logic [N_OUT-1:0]      w_hit;
    logic [N_OUT-1:0]      w_slot_free;
    logic [N_OUT-1:0]      w_push;
    logic                  w_accept;
    logic                  w_drop;
    logic [N_OUT*DATA_W-1:0] w_out_data;

    assign w_tgt    = (r_state == ST_LOCKED) ? r_locked_sel : bus.in_sel;
    assign w_tgt_ok = (r_state != ST_DROP) && ({1'b0, w_tgt} < N_OUT_L);

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_chan
            assign w_hit[gi]       = w_tgt_ok && (w_tgt == SEL_W'(gi));
            // A full slot still accepts when it is being drained this cycle
            assign w_slot_free[gi] = ~r_valid[gi] | bus.out_ready[gi];
            assign w_push[gi]      = w_accept & w_hit[gi];
        end
    endgenerate

    assign bus.in_ready = w_tgt_ok ? |(w_hit & w_slot_free) : 1'b1;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_drop       = w_accept & ~w_tgt_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (w_push[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= bus.in_data;
                end else if (bus.out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                end
            end
        end
    end

    always_comb begin
        w_out_data = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_out_data[k*DATA_W +: DATA_W] = r_data[k];
        end
    end

    assign bus.out_data  = w_out_data;
    assign bus.out_valid = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_locked_sel <= '0;
        end else begin
            r_state      <= w_state_next;
            r_locked_sel <= w_locked_sel_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_locked_sel_next = r_locked_sel;
        if ((PKT_MODE != 0) && w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    // Single-beat packets never leave IDLE
                    if (!bus.in_last) begin
                        if (w_tgt_ok) begin
                            w_state_next      = ST_LOCKED;
                            w_locked_sel_next = bus.in_sel;
                        end else begin
                            w_state_next = ST_DROP;
                        end
                    end
                end
                ST_LOCKED, ST_DROP: begin
                    if (bus.in_last) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: two instances (A: streaming, 8 ch, 4-bit counter;
// B: packet mode, 6 ch) checked against a queue-level model plus directed vectors.
module tb_demux_stream_1xn;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [3:0] drop_a;
    logic [7:0] drop_b;
    logic       busy_a, busy_b;

    demux_stream_1xn_if #(.DATA_W(8), .N_OUT(8), .SEL_W(4)) ia ();
    demux_stream_1xn_if #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) ib ();

    demux_stream_1xn #(.DATA_W(8), .N_OUT(8), .SEL_W(4), .PKT_MODE(0), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ia), .drop_cnt(drop_a), .busy(busy_a)
    );
    demux_stream_1xn #(.DATA_W(8), .N_OUT(6), .SEL_W(3), .PKT_MODE(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ib), .drop_cnt(drop_b), .busy(busy_b)
    );

    // Stimulus per instance (index 0 = A, 1 = B)
    logic       s_v    [2];
    logic [7:0] s_d    [2];
    logic [3:0] s_sel  [2];
    logic       s_last [2];
    logic [7:0] s_rdy  [2];
    logic       s_rst  [2];

    // Model: each channel is a queue of depth one (-1 = empty); lock -1 idle, -2 dropping
    int  m_hold [2][8];
    int  m_lock [2];
    int  m_drop [2];
    bit  m_known[2];
    int  n_out  [2] = '{8, 6};
    int  cnt_max[2] = '{15, 255};
    bit  pkt    [2] = '{1'b0, 1'b1};
    bit  exp_rdy[2];
    bit  tv     [2];
    int  tg     [2];

    int checks = 0;
    int errors = 0;
    logic last_rdy_b;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive();
        ia.in_valid  = s_v[0];
        ia.in_data   = s_d[0];
        ia.in_sel    = s_sel[0];
        ia.in_last   = s_last[0];
        ia.out_ready = s_rdy[0];
        rst_a        = s_rst[0];
        ib.in_valid  = s_v[1];
        ib.in_data   = s_d[1];
        ib.in_sel    = s_sel[1][2:0];
        ib.in_last   = s_last[1];
        ib.out_ready = s_rdy[1][5:0];
        rst_b        = s_rst[1];
    endtask

    task automatic predict(input int d);
        int t;
        t = (pkt[d] && m_lock[d] >= 0) ? m_lock[d] : int'(s_sel[d]);
        tg[d] = t;
        tv[d] = !(pkt[d] && m_lock[d] == -2) && (t < n_out[d]);
        if (tv[d]) exp_rdy[d] = (m_hold[d][t] < 0) || s_rdy[d][t];
        else       exp_rdy[d] = 1'b1;
    endtask

    task automatic update(input int d);
        bit acc;
        if (s_rst[d]) begin
            for (int k = 0; k < 8; k++) m_hold[d][k] = -1;
            m_lock[d]  = -1;
            m_drop[d]  = 0;
            m_known[d] = 1'b1;
            return;
        end
        acc = s_v[d] && exp_rdy[d];
        for (int k = 0; k < n_out[d]; k++)
            if (m_hold[d][k] >= 0 && s_rdy[d][k]) m_hold[d][k] = -1;
        if (acc && tv[d]) m_hold[d][tg[d]] = int'(s_d[d]);
        if (acc && !tv[d] && m_drop[d] < cnt_max[d]) m_drop[d]++;
        if (acc)
            $display("dut%0d beat data=%02h sel=%0d last=%0d -> %s", d, s_d[d], s_sel[d], s_last[d],
                     tv[d] ? $sformatf("ch%0d", tg[d]) : "dropped");
        if (acc && pkt[d]) begin
            if (m_lock[d] == -1) begin
                if (!s_last[d]) m_lock[d] = (int'(s_sel[d]) < n_out[d]) ? int'(s_sel[d]) : -2;
            end else if (s_last[d]) begin
                m_lock[d] = -1;
            end
        end
    endtask

    task automatic check_out(input int d);
        longint eov, eod, aov, aod, adrop, abusy;
        eov = 0; eod = 0;
        for (int k = 0; k < n_out[d]; k++) begin
            if (m_hold[d][k] >= 0) begin
                eov |= longint'(1) << k;
                eod |= longint'(m_hold[d][k]) << (8*k);
            end
        end
        if (d == 0) begin
            aov = longint'(ia.out_valid); aod = longint'(ia.out_data);
            adrop = longint'(drop_a); abusy = longint'(busy_a);
        end else begin
            aov = longint'(ib.out_valid); aod = longint'(ib.out_data);
            adrop = longint'(drop_b); abusy = longint'(busy_b);
        end
        chk($sformatf("dut%0d_out_valid", d), aov, eov);
        chk($sformatf("dut%0d_out_data", d), aod, eod);
        chk($sformatf("dut%0d_drop_cnt", d), adrop, longint'(m_drop[d]));
        chk($sformatf("dut%0d_busy", d), abusy, longint'(m_lock[d] != -1));
    endtask

    task automatic cycle_pre();
        drive();
        #1;
        for (int d = 0; d < 2; d++) begin
            predict(d);
            if (m_known[d])
                chk($sformatf("dut%0d_in_ready", d),
                    longint'(d == 0 ? ia.in_ready : ib.in_ready), longint'(exp_rdy[d]));
        end
    endtask

    task automatic cycle_post();
        @(posedge clk);
        for (int d = 0; d < 2; d++) update(d);
        @(negedge clk);
        for (int d = 0; d < 2; d++) if (m_known[d]) check_out(d);
    endtask

    task automatic cycle();
        cycle_pre();
        cycle_post();
    endtask

    task automatic beat_b(input logic [7:0] data, input logic [3:0] sel, input logic last);
        s_v[1] = 1'b1; s_d[1] = data; s_sel[1] = sel; s_last[1] = last;
        cycle_pre();
        last_rdy_b = ib.in_ready;
        cycle_post();
        s_v[1] = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [3:0]  sel;
        logic [7:0]  rdy;
        logic        erdy;
        logic [7:0]  eov;
        logic [63:0] eod;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 8'h11, 4'd0, 8'hFF, 1'b1, 8'h01, 64'h0000_0000_0000_0011};
        tbl[1] = '{1'b1, 8'h22, 4'd5, 8'hFF, 1'b1, 8'h20, 64'h0000_2200_0000_0000};
        tbl[2] = '{1'b1, 8'h33, 4'd7, 8'hFF, 1'b1, 8'h80, 64'h3300_0000_0000_0000};
        tbl[3] = '{1'b0, 8'h00, 4'd0, 8'hFF, 1'b1, 8'h00, 64'h0};
        tbl[4] = '{1'b1, 8'hA1, 4'd3, 8'hF7, 1'b1, 8'h08, 64'h0000_0000_A100_0000};
        tbl[5] = '{1'b1, 8'hA2, 4'd3, 8'hF7, 1'b0, 8'h08, 64'h0000_0000_A100_0000};
        tbl[6] = '{1'b1, 8'hA2, 4'd3, 8'hFF, 1'b1, 8'h08, 64'h0000_0000_A200_0000};
        tbl[7] = '{1'b1, 8'hB4, 4'd4, 8'hF7, 1'b1, 8'h18, 64'h0000_00B4_A200_0000};
        tbl[8] = '{1'b0, 8'h00, 4'd0, 8'hFF, 1'b1, 8'h00, 64'h0};

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) m_hold[d][k] = -1;
            m_lock[d] = -1; m_drop[d] = 0; m_known[d] = 1'b0; exp_rdy[d] = 1'b1;
            s_v[d] = 1'b0; s_d[d] = '0; s_sel[d] = '0; s_last[d] = 1'b0;
            s_rdy[d] = 8'hFF; s_rst[d] = 1'b1;
        end
        @(negedge clk);
        cycle();
        cycle();
        s_rst[0] = 1'b0; s_rst[1] = 1'b0;
        chk("reset_out_valid_a", longint'(ia.out_valid), 0);
        chk("reset_busy_b", longint'(busy_b), 0);

        // Routing and backpressure on the streaming instance
        foreach (tbl[i]) begin
            s_v[0] = tbl[i].v; s_d[0] = tbl[i].d; s_sel[0] = tbl[i].sel; s_rdy[0] = tbl[i].rdy;
            cycle_pre();
            chk($sformatf("tbl%0d_in_ready", i), longint'(ia.in_ready), longint'(tbl[i].erdy));
            cycle_post();
            chk($sformatf("tbl%0d_out_valid", i), longint'(ia.out_valid), longint'(tbl[i].eov));
            chk($sformatf("tbl%0d_out_data", i), longint'(ia.out_data), longint'(tbl[i].eod));
        end

        // Drop counter saturation at 15
        for (int i = 0; i < 20; i++) begin
            s_v[0] = 1'b1; s_d[0] = 8'(i); s_sel[0] = 4'(8 + (i % 8));
            cycle();
            chk($sformatf("sat_cnt%0d", i), longint'(drop_a), longint'((i + 1 > 15) ? 15 : i + 1));
        end
        s_v[0] = 1'b0;
        cycle();

        // Packet lock: later in_sel values ignored
        s_rdy[1] = 8'h3F;
        beat_b(8'hC1, 4'd2, 1'b0);
        chk("lock_b1_busy", longint'(busy_b), 1);
        chk("lock_b1_data", longint'(ib.out_data[23:16]), 'hC1);
        beat_b(8'hC2, 4'd6, 1'b0);
        chk("lock_b2_valid", longint'(ib.out_valid), 'h04);
        chk("lock_b2_data", longint'(ib.out_data[23:16]), 'hC2);
        beat_b(8'hC3, 4'd6, 1'b0);
        chk("lock_b3_data", longint'(ib.out_data[23:16]), 'hC3);
        beat_b(8'hC4, 4'd6, 1'b1);
        chk("lock_b4_data", longint'(ib.out_data[23:16]), 'hC4);
        chk("lock_b4_busy", longint'(busy_b), 0);
        beat_b(8'hC5, 4'd5, 1'b1);
        chk("next_pkt_valid", longint'(ib.out_valid), 'h20);
        chk("next_pkt_data", longint'(ib.out_data[47:40]), 'hC5);
        cycle();

        // Invalid first select: whole packet discarded
        for (int i = 0; i < 3; i++) begin
            beat_b(8'(8'hE1 + i), (i == 0) ? 4'd7 : 4'd0, (i == 2));
            chk($sformatf("inv%0d_in_ready", i), longint'(last_rdy_b), 1);
            chk($sformatf("inv%0d_out_valid", i), longint'(ib.out_valid), 0);
            chk($sformatf("inv%0d_drop", i), longint'(drop_b), longint'(i + 1));
            chk($sformatf("inv%0d_busy", i), longint'(busy_b), longint'(i < 2));
        end

        // Reset in the middle of a locked packet with its channel stalled
        s_rdy[1] = 8'h3D;
        beat_b(8'hD1, 4'd1, 1'b0);
        beat_b(8'hD2, 4'd1, 1'b0);
        chk("midrst_stall_ready", longint'(last_rdy_b), 0);
        s_v[1] = 1'b1; s_rst[1] = 1'b1;
        cycle();
        s_v[1] = 1'b0; s_rst[1] = 1'b0; s_rdy[1] = 8'h3F;
        chk("midrst_valid", longint'(ib.out_valid), 0);
        chk("midrst_busy", longint'(busy_b), 0);
        chk("midrst_drop", longint'(drop_b), 0);
        beat_b(8'hF4, 4'd4, 1'b1);
        chk("midrst_after_valid", longint'(ib.out_valid), 'h10);
        chk("midrst_after_data", longint'(ib.out_data[39:32]), 'hF4);
        cycle();

        // Randomised traffic on both instances; held beats stay stable until accepted
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!(s_v[d] && !exp_rdy[d]) || s_rst[d]) begin
                    s_v[d]    = ($urandom_range(0, 3) != 0);
                    s_d[d]    = 8'($urandom);
                    if (d == 0)
                        s_sel[d] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15))
                                                                : 4'($urandom_range(0, 7));
                    else
                        s_sel[d] = 4'($urandom_range(0, 7));
                    s_last[d] = ($urandom_range(0, 3) == 0);
                end
                s_rdy[d] = 8'($urandom | $urandom);
            end
            s_rst[1] = ($urandom_range(0, 63) == 0);
            cycle();
        end
        s_rst[1] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
